// File: rtl/led_alert_pkg.sv
// Shared types and widths for the LED alert sequencer.
package led_alert_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam int CFG_MS_W  = 16;
  localparam int CFG_CNT_W = 4;

  // A zero duration still lasts one tick, so no phase is ever skipped.
  function automatic logic [CFG_MS_W-1:0] ms_at_least_one(input logic [CFG_MS_W-1:0] ms);
    return (ms == '0) ? CFG_MS_W'(1) : ms;
  endfunction

  function automatic logic [CFG_CNT_W-1:0] cnt_at_least_one(input logic [CFG_CNT_W-1:0] cnt);
    return (cnt == '0) ? CFG_CNT_W'(1) : cnt;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick divider: counts 0..TICK_DIV-1, emits a one-cycle tick on the last count.
module ms_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [DIV_W-1:0] div_reg;

  assign tick = (div_reg == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_reg <= '0;
    end else if (clr || tick) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_reg + 1'b1;
    end
  end

endmodule

// File: rtl/led_alert_sequencer.sv
// Fixed-priority, non-preemptive arbiter driving one status LED with per-requester flash bursts.
// Optional idle heartbeat is built only when LED_ALERT_HEARTBEAT_EN is defined.
module led_alert_sequencer
  import led_alert_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int TICK_DIV = 50000,
  parameter int GAP_MS   = 500,
  parameter int HB_MS    = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [CFG_MS_W*NREQ-1:0]  cfg_on_ms,
  input  logic [CFG_MS_W*NREQ-1:0]  cfg_off_ms,
  input  logic [CFG_CNT_W*NREQ-1:0] cfg_cnt,
  output logic [NREQ-1:0]           grant,
  output logic [NREQ-1:0]           done,
  output logic                      busy,
  output logic                      led
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CFG_MS_W-1:0] GAP_LEN = CFG_MS_W'(GAP_MS);

  if (GAP_MS < 1 || GAP_MS > 65535 || HB_MS < 1 || HB_MS > 65535 || TICK_DIV < 1) begin : g_param_check
    $error("led_alert_sequencer: GAP_MS/HB_MS must be 1..65535 and TICK_DIV >= 1");
  end

  state_t                state_reg, state_next;
  logic [NREQ-1:0]       grant_reg;
  logic [CFG_MS_W-1:0]   on_len_reg, off_len_reg;
  logic [CFG_CNT_W-1:0]  flash_reg;
  logic [CFG_MS_W-1:0]   phase_reg;
  logic [CFG_MS_W-1:0]   phase_len;
  logic                  phase_end;
  logic                  tick;
  logic                  clr;
  logic                  hb_led;

  logic [CFG_MS_W-1:0]   on_ms_arr  [NREQ];
  logic [CFG_MS_W-1:0]   off_ms_arr [NREQ];
  logic [CFG_CNT_W-1:0]  cnt_arr    [NREQ];
  logic [IDX_W-1:0]      pick_idx;
  logic [NREQ-1:0]       pick_onehot;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign on_ms_arr[gi]  = cfg_on_ms[CFG_MS_W*gi +: CFG_MS_W];
    assign off_ms_arr[gi] = cfg_off_ms[CFG_MS_W*gi +: CFG_MS_W];
    assign cnt_arr[gi]    = cfg_cnt[CFG_CNT_W*gi +: CFG_CNT_W];
  end

  // Lowest requesting index wins.
  always_comb begin
    pick_idx    = '0;
    pick_onehot = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        pick_idx = IDX_W'(i);
      end
    end
    if (|req) begin
      pick_onehot[pick_idx] = 1'b1;
    end
  end

  ms_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  always_comb begin
    case (state_reg)
      ON:      phase_len = on_len_reg;
      OFF:     phase_len = off_len_reg;
      default: phase_len = GAP_LEN;
    endcase
  end

  assign phase_end = tick && (phase_reg == phase_len - 1'b1);
  assign clr       = (state_next != state_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (|req)     state_next = ON;
      ON:   if (phase_end) state_next = OFF;
      OFF:  if (phase_end) state_next = (flash_reg <= CFG_CNT_W'(1)) ? GAP : ON;
      GAP:  if (phase_end) state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  // Burst configuration is captured only at grant; later cfg changes wait for the next grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_reg   <= '0;
      flash_reg   <= '0;
      on_len_reg  <= '0;
      off_len_reg <= '0;
      grant_reg   <= '0;
    end else begin
      if (clr) begin
        phase_reg <= '0;
      end else if (tick && state_reg != IDLE) begin
        phase_reg <= phase_reg + 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (|req) begin
            grant_reg   <= pick_onehot;
            on_len_reg  <= ms_at_least_one(on_ms_arr[pick_idx]);
            off_len_reg <= ms_at_least_one(off_ms_arr[pick_idx]);
            flash_reg   <= cnt_at_least_one(cnt_arr[pick_idx]);
          end
        end
        OFF: begin
          if (phase_end && flash_reg != '0) begin
            flash_reg <= flash_reg - 1'b1;
          end
        end
        GAP: begin
          if (phase_end) begin
            grant_reg <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LED_ALERT_HEARTBEAT_EN
  localparam logic [CFG_MS_W-1:0] HB_LEN = CFG_MS_W'(HB_MS);

  logic [CFG_MS_W-1:0] hb_cnt_reg;
  logic                hb_led_reg;

  // Heartbeat restarts dark on every IDLE entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hb_cnt_reg <= '0;
      hb_led_reg <= 1'b0;
    end else if (state_reg != IDLE || clr) begin
      hb_cnt_reg <= '0;
      hb_led_reg <= 1'b0;
    end else if (tick) begin
      if (hb_cnt_reg == HB_LEN - 1'b1) begin
        hb_cnt_reg <= '0;
        hb_led_reg <= ~hb_led_reg;
      end else begin
        hb_cnt_reg <= hb_cnt_reg + 1'b1;
      end
    end
  end

  assign hb_led = hb_led_reg;
`else
  assign hb_led = 1'b0;
`endif

  always_comb begin
    busy  = (state_reg != IDLE);
    led   = (state_reg == ON) || ((state_reg == IDLE) && hb_led);
    grant = grant_reg;
    done  = '0;
    if (state_reg == GAP && phase_end) begin
      done = grant_reg;
    end
  end

endmodule
